booth_input_module: RTL and testbench
=====================================

Name: booth_input_module

Overview:
- Entry stage of the pipelined 8x8 signed radix-2 Booth multiplier.
- Accepts operand pairs on a valid/ready handshake and builds the initial partial-product word and the multiplicand-pair word that the first booth_process_module stage consumes.
- Carries a valid/tag/unsafe side-band down a delay line matched to the process-stage chain, so the result is marked valid when the last stage's output is final.
- Limits issue with a credit counter sized to the downstream result buffer. The process stages cannot stall, so credits are the only flow control.

Parameters:
- WIDTH, 8, operand width. Fixed at 8; the process stages are 8-bit.
- STAGES, 8, number of booth_process_module stages downstream.
- TAG_W, 4, width of the user tag carried with each operation.
- CREDITS, 4, depth of the downstream result buffer, i.e. the maximum number of operations in flight.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand pair presented
- in_ready  out  1  stage can accept (credits available)
- in_a  in  8  multiplicand, signed two's complement
- in_b  in  8  multiplier, signed two's complement
- in_tag  in  TAG_W  user tag
- temp_out  out  17  initial partial-product word, to stage 1 temp_in
- item_out  out  16  {-A, A}, to stage 1 item_in
- res_valid  out  1  last process stage's temp_out[16:1] holds a valid product this cycle
- res_tag  out  TAG_W  tag aligned with res_valid
- res_unsafe  out  1  operation had in_a = 8'h80; product not guaranteed
- credit_return  in  1  downstream consumer freed one buffer entry
- credits_avail  out  $clog2(CREDITS+1)  current credit count
- err_credit_ovf  out  1  sticky: credit_return received while credits_avail == CREDITS

Behaviour:
- Reset (async on rst high):
  - temp_out = 0, item_out = 0, res_valid = 0, res_tag = 0, res_unsafe = 0.
  - Whole delay line cleared, credits_avail = CREDITS, err_credit_ovf = 0.
- in_ready = (credits_avail != 0). It is combinational from the credit register and independent of in_valid.
- accept = in_valid & in_ready.
- On an accept edge:
  - temp_out <= {8'd0, in_b, 1'b0}.
  - item_out <= {(~in_a + 1)[7:0], in_a}. Negation wraps mod 256.
- On a non-accept edge: temp_out <= 0 and item_out <= 0. Bubbles propagate as zeros.
- Delay line:
  - Total depth STAGES+1 flops of {valid, tag, unsafe}.
  - Flop 0 loads {accept, in_tag, accept & (in_a == 8'h80)} on the same edge as temp_out.
  - Each later flop shifts every cycle, unconditionally.
  - res_* are driven from the final flop.
- Latency: accept at edge N → res_valid high in the cycle after edge N+STAGES (9 register delays including the input register).
- Throughput: one operation per cycle while credits last.
- Credits:
  - accept only → credits_avail - 1.
  - credit_return only → credits_avail + 1, saturating at CREDITS.
  - Both in the same cycle → unchanged.
  - Neither → unchanged.
- credit_return while credits_avail == CREDITS (and no accept that cycle):
  - Count stays at CREDITS.
  - err_credit_ovf set; it clears only on rst.
- credits_avail never underflows, because accept requires in_ready.
- Reset mid-operation discards all in-flight operations. No res_valid is produced for them, and credits restore to CREDITS.
- in_a/in_b/in_tag may change freely while in_valid is low. When in_ready is low, no capture occurs and the pair is held by the producer.

Decomposition:
- booth_pkg:
  - WIDTH = 8, STAGES = 8, LAT = STAGES+1.
  - TEMP_W = 2*WIDTH+1 = 17, ITEM_W = 2*WIDTH = 16.
  - A_MIN = 8'h80.
  - Typedef of the side-band struct {valid, tag, unsafe}.
- One sub-module: booth_sideband_delay, a parameterised depth-LAT shift register of the side-band struct with async active-high clear.
- Credit counter and operand encode stay in booth_input_module.

Test Plan:
- Reset, then in_valid=1, a=3, b=5, tag=1 → next edge:
  - temp_out = 17'h0000A, item_out = 16'hFD03.
  - res_valid=1 with res_tag=1 nine cycles after accept.
  - Chained with 8 process stages, final temp[16:1] = 16'd15.
- a=-7 (8'hF9), b=9 → item_out = 16'h07F9; product via chain = 16'hFFC1 (-63); res_unsafe=0.
- a=8'h80, b=1 → item_out = 16'h8080, res_unsafe=1 aligned with res_valid.
- Back-to-back accepts with CREDITS=4 and no credit_return:
  - Exactly 4 accepts; in_ready=0 from the cycle after the 4th; credits_avail=0.
  - One credit_return → credits_avail=1, in_ready=1.
- Simultaneous accept and credit_return at credits_avail=2 → stays 2. credit_return at credits_avail=4 → stays 4, err_credit_ovf=1 and sticky.
- Assert rst with 3 operations in flight → all outputs zero immediately; no res_valid in the following 12 cycles; credits_avail=4 after release.

Source files
------------

// File: rtl/booth_pkg.sv
// booth_pkg: shared constants, side-band type and negation helper for the Booth multiplier entry stage
// Contents:
//   WIDTH/STAGES/LAT     operand width, process-stage count, side-band delay depth
//   TAG_W/CREDITS        user tag width, downstream result buffer depth
//   TEMP_W/ITEM_W        partial-product and multiplicand-pair word widths
//   A_MIN                the one multiplicand whose negation overflows
//   sideband_t           {valid, tag, unsafe} carried alongside each operation
//   neg()                two's complement negation, wrapping mod 2^WIDTH
package booth_pkg;
    localparam int WIDTH   = 8;
    localparam int STAGES  = 8;
    localparam int LAT     = STAGES + 1;
    localparam int TAG_W   = 4;
    localparam int CREDITS = 4;
    localparam int TEMP_W  = 2 * WIDTH + 1;
    localparam int ITEM_W  = 2 * WIDTH;
    localparam logic [WIDTH-1:0] A_MIN = 8'h80;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic             unsafe;
    } sideband_t;

    function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] a);
        return ~a + WIDTH'(1);
    endfunction
endpackage

// File: rtl/booth_sideband_delay.sv
// booth_sideband_delay: fixed-depth shift register keeping side-band aligned with the process-stage chain
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high clear of the whole line
//   i_d   side-band entering at flop 0
//   o_q   side-band leaving the final flop
module booth_sideband_delay
    import booth_pkg::*;
#(
    parameter int DEPTH = LAT
) (
    input  logic      clk,
    input  logic      rst,
    input  sideband_t i_d,
    output sideband_t o_q
);
    sideband_t [DEPTH-1:0] r_line;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_line <= '0;
        else     r_line <= {r_line[DEPTH-2:0], i_d};
    end

    assign o_q = r_line[DEPTH-1];
endmodule

// File: rtl/booth_input_module.sv
// booth_input_module: entry stage of the pipelined signed radix-2 Booth multiplier with credit flow control
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready        operand handshake; ready while credits remain
//   in_a, in_b, in_tag       multiplicand, multiplier, user tag
//   temp_out                 initial partial-product word {0, b, 0}
//   item_out                 multiplicand pair {-a, a}
//   res_valid/tag/unsafe     side-band aligned with the last process stage's output
//   credit_return            downstream freed one result buffer entry
//   credits_avail            current credit count
//   err_credit_ovf           sticky: credit returned while already full
module booth_input_module #(
    parameter int WIDTH   = booth_pkg::WIDTH,
    parameter int STAGES  = booth_pkg::STAGES,
    parameter int TAG_W   = booth_pkg::TAG_W,
    parameter int CREDITS = booth_pkg::CREDITS,
    localparam int CW     = $clog2(CREDITS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [TAG_W-1:0]   in_tag,
    output logic [2*WIDTH:0]   temp_out,
    output logic [2*WIDTH-1:0] item_out,
    output logic               res_valid,
    output logic [TAG_W-1:0]   res_tag,
    output logic               res_unsafe,
    input  logic               credit_return,
    output logic [CW-1:0]      credits_avail,
    output logic               err_credit_ovf
);
    import booth_pkg::sideband_t;
    import booth_pkg::A_MIN;
    import booth_pkg::neg;

    logic [2*WIDTH:0]   r_temp;
    logic [2*WIDTH-1:0] r_item;
    logic [CW-1:0]      r_credits;
    logic               r_err;
    logic               w_accept;
    logic               w_ovf;
    logic [CW-1:0]      w_credits_nxt;
    sideband_t          w_sb_in;
    sideband_t          w_sb_out;

    assign in_ready = r_credits != '0;
    assign w_accept = in_valid & in_ready;

    // An accept paired with a return is a wash; a lone return saturates at full.
    always_comb begin
        w_ovf         = credit_return & ~w_accept & (r_credits == CW'(CREDITS));
        w_credits_nxt = (w_accept & ~credit_return)        ? r_credits - CW'(1) :
                        (credit_return & ~w_accept & ~w_ovf) ? r_credits + CW'(1) :
                                                              r_credits;
    end

    assign w_sb_in = '{valid: w_accept, tag: in_tag, unsafe: w_accept & (in_a == A_MIN)};

    // Non-accept cycles load zeros so bubbles flow through the stages harmlessly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_temp    <= '0;
            r_item    <= '0;
            r_credits <= CW'(CREDITS);
            r_err     <= 1'b0;
        end else begin
            r_temp    <= w_accept ? {WIDTH'(0), in_b, 1'b0} : '0;
            r_item    <= w_accept ? {neg(in_a), in_a} : '0;
            r_credits <= w_credits_nxt;
            r_err     <= r_err | w_ovf;
        end
    end

    booth_sideband_delay #(.DEPTH(STAGES + 1)) u_delay (
        .clk (clk),
        .rst (rst),
        .i_d (w_sb_in),
        .o_q (w_sb_out)
    );

    assign temp_out       = r_temp;
    assign item_out       = r_item;
    assign res_valid      = w_sb_out.valid;
    assign res_tag        = w_sb_out.tag;
    assign res_unsafe     = w_sb_out.unsafe;
    assign credits_avail  = r_credits;
    assign err_credit_ovf = r_err;
endmodule

// File: tb/tb_booth_input_module.sv
// tb_booth_input_module: directed bench with a time-scheduled behavioural model for booth_input_module
module tb_booth_input_module;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_a = '0;
    logic [7:0]  in_b = '0;
    logic [3:0]  in_tag = '0;
    logic [16:0] temp_out;
    logic [15:0] item_out;
    logic        res_valid;
    logic [3:0]  res_tag;
    logic        res_unsafe;
    logic        credit_return = 1'b0;
    logic [2:0]  credits_avail;
    logic        err_credit_ovf;

    int total = 0;
    int bad = 0;
    bit go = 1'b0;

    booth_input_module dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .temp_out(temp_out), .item_out(item_out),
        .res_valid(res_valid), .res_tag(res_tag), .res_unsafe(res_unsafe),
        .credit_return(credit_return), .credits_avail(credits_avail), .err_credit_ovf(err_credit_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference radix-2 Booth over 8 steps, used to prove the encoded words give the right product.
    function automatic logic [15:0] booth_chain(input logic [16:0] t, input logic [15:0] it);
        for (int k = 0; k < 8; k++) begin
            if (t[1:0] == 2'b01)      t[16:9] = t[16:9] + it[7:0];
            else if (t[1:0] == 2'b10) t[16:9] = t[16:9] + it[15:8];
            t = {t[16], t[16:1]};
        end
        return t[16:1];
    endfunction

    // Model: results are scheduled by absolute edge number, 8 edges after the accepting edge.
    int          m_cred;
    logic        m_err;
    logic [16:0] m_temp;
    logic [15:0] m_item;
    logic [5:0]  m_res;
    logic [5:0]  sched [16];
    int          ecnt;
    logic        m_acc;
    logic [7:0]  m_na;

    assign m_acc = in_valid && (m_cred != 0);
    assign m_na  = 8'd0 - in_a;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cred <= 4;
            m_err  <= 1'b0;
            m_temp <= '0;
            m_item <= '0;
            m_res  <= '0;
            ecnt   <= 0;
            for (int i = 0; i < 16; i++) sched[i] <= '0;
        end else begin
            m_temp <= m_acc ? {8'd0, in_b, 1'b0} : 17'd0;
            m_item <= m_acc ? {m_na, in_a} : 16'd0;
            m_res  <= sched[ecnt % 16];
            sched[ecnt % 16] <= '0;
            if (m_acc) sched[(ecnt + 8) % 16] <= {1'b1, in_tag, in_a == 8'h80};
            ecnt <= ecnt + 1;
            if (m_acc && !credit_return) m_cred <= m_cred - 1;
            else if (credit_return && !m_acc) begin
                if (m_cred == 4) m_err <= 1'b1;
                else m_cred <= m_cred + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (go) begin
            check("temp_out", 32'(temp_out), 32'(m_temp));
            check("item_out", 32'(item_out), 32'(m_item));
            check("res_valid", 32'(res_valid), 32'(m_res[5]));
            if (m_res[5]) begin
                check("res_tag", 32'(res_tag), 32'(m_res[4:1]));
                check("res_unsafe", 32'(res_unsafe), 32'(m_res[0]));
            end
            check("credits_avail", 32'(credits_avail), 32'(m_cred));
            check("in_ready", 32'(in_ready), 32'(m_cred != 0));
            check("err_credit_ovf", 32'(err_credit_ovf), 32'(m_err));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_res(output int n);
        n = 0;
        while (!res_valid && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic one_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] tag,
                          input logic [15:0] exp_item, input logic exp_unsafe);
        int n;
        in_valid = 1'b1; in_a = a; in_b = b; in_tag = tag;
        tick();
        in_valid = 1'b0; in_a = 8'h5A; in_b = 8'hA5; in_tag = 4'hF;
        check("lit_temp", 32'(temp_out), 32'({8'd0, b, 1'b0}));
        check("lit_item", 32'(item_out), 32'(exp_item));
        wait_res(n);
        check("lit_latency", 32'(n), 32'd8);
        check("lit_res_tag", 32'(res_tag), 32'(tag));
        check("lit_res_unsafe", 32'(res_unsafe), 32'(exp_unsafe));
        credit_return = 1'b1;
        tick();
        credit_return = 1'b0;
        check("lit_credit_back", 32'(credits_avail), 32'd4);
    endtask

    initial begin
        int acc;
        int seen;
        #1 rst = 1'b1;
        go = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        check("lit_reset_credits", 32'(credits_avail), 32'd4);
        check("lit_reset_temp", 32'(temp_out), 32'd0);
        check("lit_reset_ready", 32'(in_ready), 32'd1);

        in_valid = 1'b1; in_a = 8'd3; in_b = 8'd5; in_tag = 4'd1;
        tick();
        in_valid = 1'b0;
        check("lit_3x5_temp", 32'(temp_out), 32'h0000A);
        check("lit_3x5_item", 32'(item_out), 32'hFD03);
        check("lit_3x5_product", 32'(booth_chain(temp_out, item_out)), 32'd15);
        check("lit_3x5_credits", 32'(credits_avail), 32'd3);
        repeat (7) tick();
        check("lit_3x5_not_yet", 32'(res_valid), 32'd0);
        tick();
        check("lit_3x5_valid", 32'(res_valid), 32'd1);
        check("lit_3x5_tag", 32'(res_tag), 32'd1);
        tick();
        check("lit_3x5_valid_once", 32'(res_valid), 32'd0);
        credit_return = 1'b1;
        tick();
        credit_return = 1'b0;

        in_valid = 1'b1; in_a = 8'hF9; in_b = 8'd9; in_tag = 4'd2;
        tick();
        in_valid = 1'b0;
        check("lit_m7x9_product", 32'(booth_chain(temp_out, item_out)), 32'hFFC1);
        repeat (8) tick();
        credit_return = 1'b1;
        tick();
        credit_return = 1'b0;

        one_op(8'hF9, 8'd9, 4'd2, 16'h07F9, 1'b0);
        one_op(8'h80, 8'd1, 4'd3, 16'h8080, 1'b1);
        one_op(8'h7F, 8'h80, 4'd9, 16'h817F, 1'b0);

        acc = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_a = 8'(i * 17 + 1); in_b = 8'(8'hF0 - i); in_tag = 4'(i + 4);
            if (in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        check("lit_b2b_accepts", 32'(acc), 32'd4);
        check("lit_b2b_credits", 32'(credits_avail), 32'd0);
        check("lit_b2b_ready", 32'(in_ready), 32'd0);
        credit_return = 1'b1;
        tick();
        credit_return = 1'b0;
        check("lit_ret_credits", 32'(credits_avail), 32'd1);
        check("lit_ret_ready", 32'(in_ready), 32'd1);
        repeat (12) tick();
        credit_return = 1'b1;
        repeat (3) tick();
        credit_return = 1'b0;
        check("lit_refill", 32'(credits_avail), 32'd4);

        in_valid = 1'b1; in_a = 8'd11; in_b = 8'd12; in_tag = 4'd7;
        repeat (2) tick();
        check("lit_two_taken", 32'(credits_avail), 32'd2);
        credit_return = 1'b1;
        tick();
        in_valid = 1'b0;
        check("lit_simul", 32'(credits_avail), 32'd2);
        repeat (2) tick();
        check("lit_full_no_err", 32'(err_credit_ovf), 32'd0);
        tick();
        credit_return = 1'b0;
        check("lit_ovf_sat", 32'(credits_avail), 32'd4);
        check("lit_ovf_err", 32'(err_credit_ovf), 32'd1);
        repeat (3) tick();
        check("lit_ovf_sticky", 32'(err_credit_ovf), 32'd1);
        repeat (10) tick();

        in_valid = 1'b1; in_a = 8'h22; in_b = 8'h33; in_tag = 4'd5;
        repeat (3) tick();
        in_valid = 1'b0;
        repeat (2) tick();
        #2 rst = 1'b1;
        #1;
        check("lit_rst_temp", 32'(temp_out), 32'd0);
        check("lit_rst_item", 32'(item_out), 32'd0);
        check("lit_rst_valid", 32'(res_valid), 32'd0);
        check("lit_rst_credits", 32'(credits_avail), 32'd4);
        check("lit_rst_err", 32'(err_credit_ovf), 32'd0);
        tick();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (res_valid) seen++;
        end
        check("lit_rst_no_results", 32'(seen), 32'd0);
        check("lit_rst_credits_after", 32'(credits_avail), 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
